// File: rtl/snake_pkg.sv
// Shared types for the snake game core.
//   dir_t        : 2-bit heading encoding (left=00, down=01, up=10, right=11)
//   DIR_RESET    : heading after reset or restart
//   is_opposite  : true when two headings point in exactly opposite directions
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    // The encoding puts opposite directions at bitwise complements.
    function automatic logic is_opposite(dir_t a, dir_t b);
        return (a ^ b) == 2'b11;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-flop synchroniser, counter debounce, press pulse.
//   clk     : system clock
//   clear_n : asynchronous active-low reset
//   btn     : raw asynchronous button level (active-high)
//   rise    : 1-cycle pulse in the cycle the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 10000
) (
    input  logic clk,
    input  logic clear_n,
    input  logic btn,
    output logic rise
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Flagged in the same cycle stable is about to flip high, so the event
    // reaches the queue on the same edge that accepts the new level.
    assign rise = sync2_q && !stable_q && (cnt_q == CntMax);

endmodule

// File: rtl/dir_input_ctrl.sv
// Direction input controller: turns four raw buttons into a committed heading.
//   clk       : system clock
//   clear_n   : asynchronous active-low reset
//   direction : raw buttons [3]=right [2]=up [1]=down [0]=left
//   move_tick : 1-cycle pulse, commits the oldest queued turn
//   restart   : synchronous restart, flushes queue and heading (debounce kept)
//   heading   : committed direction
//   q_count   : number of queued turns
//   overflow  : 1-cycle pulse when a legal press is dropped on a full queue
module dir_input_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 10000,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] direction,
    input  logic       move_tick,
    input  logic       restart,
    output logic [1:0] heading,
    output logic [2:0] q_count,
    output logic       overflow
);

    localparam logic [1:0] LastPtr = 2'(QDEPTH - 1);
    localparam logic [2:0] FullCnt = 3'(QDEPTH);

    logic [3:0] rise;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_btn (
            .clk    (clk),
            .clear_n(clear_n),
            .btn    (direction[i]),
            .rise   (rise[i])
        );
    end

    dir_t       heading_q;
    dir_t       q_mem_q [4];
    logic [1:0] rd_ptr_q;
    logic [1:0] wr_ptr_q;
    logic [2:0] count_q;
    logic       overflow_q;

    function automatic logic [1:0] ptr_inc(logic [1:0] p);
        return (p == LastPtr) ? 2'd0 : p + 2'd1;
    endfunction

    logic       ev_valid;
    dir_t       ev_dir;
    dir_t       ref_dir;
    logic [1:0] newest_ptr;
    logic       legal;
    logic       pop;
    logic       full;
    logic       push;
    logic       drop;

    always_comb begin
        ev_valid = |rise;
        // Fixed priority; losing events are discarded rather than deferred.
        if (rise[3])      ev_dir = DIR_RIGHT;
        else if (rise[0]) ev_dir = DIR_LEFT;
        else if (rise[1]) ev_dir = DIR_DOWN;
        else              ev_dir = DIR_UP;

        newest_ptr = (wr_ptr_q == 2'd0) ? LastPtr : wr_ptr_q - 2'd1;
        // Compare against where the snake will be heading once the queue
        // drains, sampled before any pop in this cycle.
        ref_dir = (count_q != 3'd0) ? q_mem_q[newest_ptr] : heading_q;
        legal   = ev_valid && (ev_dir != ref_dir) && !is_opposite(ev_dir, ref_dir);

        pop  = move_tick && (count_q != 3'd0);
        full = (count_q == FullCnt);
        push = legal && (!full || pop);
        drop = legal && full && !pop;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            heading_q  <= DIR_RESET;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 4; i++) q_mem_q[i] <= DIR_LEFT;
        end else if (restart) begin
            heading_q  <= DIR_RESET;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (push) begin
                q_mem_q[wr_ptr_q] <= ev_dir;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                heading_q <= q_mem_q[rd_ptr_q];
                rd_ptr_q  <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop)      count_q <= count_q + 3'd1;
            else if (pop && !push) count_q <= count_q - 3'd1;
        end
    end

    assign heading  = heading_q;
    assign q_count  = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
`timescale 1ns/1ps
module tb_dir_input_ctrl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [3:0] direction;
    logic       move_tick;
    logic       restart;
    logic [1:0] heading;
    logic [2:0] q_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    dir_input_ctrl #(
        .DEB_CYCLES(4),
        .QDEPTH    (2)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .direction(direction),
        .move_tick(move_tick),
        .restart  (restart),
        .heading  (heading),
        .q_count  (q_count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold long enough to debounce the press and the release.
    task automatic press(input logic [3:0] mask);
        direction = mask;
        cycles(8);
        direction = 4'b0000;
        cycles(8);
    endtask

    task automatic tick();
        move_tick = 1'b1;
        cycles(1);
        move_tick = 1'b0;
    endtask

    initial begin
        clear_n   = 1'b0;
        direction = 4'b0000;
        move_tick = 1'b0;
        restart   = 1'b0;
        cycles(2);
        check("rst_heading", heading, 4'h3);
        check("rst_qcount", q_count, 4'h0);
        check("rst_overflow", overflow, 4'h0);
        clear_n = 1'b1;
        cycles(2);

        // Build non-reset state, then reset mid-debounce.
        press(4'b0100);                 // up
        tick();
        check("pre_heading_up", heading, 4'h2);
        press(4'b0001);                 // left, legal vs up
        check("pre_q1", q_count, 4'h1);
        direction = 4'b1000;
        cycles(4);
        clear_n = 1'b0;
        #1;
        check("async_heading", heading, 4'h3);
        check("async_qcount", q_count, 4'h0);
        check("async_overflow", overflow, 4'h0);
        direction = 4'b0000;
        cycles(2);
        clear_n = 1'b1;
        cycles(10);
        check("inflight_lost", q_count, 4'h0);

        // Bounce: 3-cycle pulses never debounce.
        for (int i = 0; i < 3; i++) begin
            direction = 4'b0100;
            cycles(3);
            direction = 4'b0000;
            cycles(3);
        end
        cycles(6);
        check("bounce_q0", q_count, 4'h0);
        direction = 4'b0100;
        cycles(5);
        check("lat_before", q_count, 4'h0);
        cycles(1);
        check("lat_at6", q_count, 4'h1);
        cycles(4);
        direction = 4'b0000;
        cycles(8);
        check("release_noevent", q_count, 4'h1);
        tick();
        check("tick_up", heading, 4'h2);
        check("tick_up_q", q_count, 4'h0);

        // Reversal and duplicate from heading right.
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        check("restart_heading", heading, 4'h3);
        press(4'b0001);
        check("reversal_rej", q_count, 4'h0);
        press(4'b1000);
        check("dup_rej", q_count, 4'h0);
        check("rej_no_ovf", overflow, 4'h0);

        // Double turn.
        press(4'b0010);
        press(4'b0001);
        check("double_q2", q_count, 4'h2);
        tick();
        check("tick1_down", heading, 4'h1);
        tick();
        check("tick2_left", heading, 4'h0);
        press(4'b0010);                 // down, legal vs left
        check("down_q1", q_count, 4'h1);
        press(4'b0100);                 // up reverses queued down
        check("up_vs_queued_rej", q_count, 4'h1);
        tick();
        check("tick_down", heading, 4'h1);

        // Overflow from heading down: queue [left, up], then right.
        press(4'b0001);
        press(4'b0100);
        check("fill_q2", q_count, 4'h2);
        direction = 4'b1000;
        cycles(5);
        check("ovf_before", overflow, 4'h0);
        cycles(1);
        check("ovf_pulse", overflow, 4'h1);
        check("ovf_q2", q_count, 4'h2);
        cycles(1);
        check("ovf_one_cycle", overflow, 4'h0);
        direction = 4'b0000;
        cycles(8);
        direction = 4'b1000;
        cycles(5);
        move_tick = 1'b1;
        cycles(1);
        move_tick = 1'b0;
        check("pushpop_ovf", overflow, 4'h0);
        check("pushpop_q", q_count, 4'h2);
        check("pushpop_head", heading, 4'h0);
        direction = 4'b0000;
        cycles(8);
        tick();
        check("drain_up", heading, 4'h2);
        tick();
        check("drain_right", heading, 4'h3);
        check("drain_q0", q_count, 4'h0);

        // Simultaneous right+down from heading up: only right queued.
        press(4'b0100);
        tick();
        check("sim_pre_up", heading, 4'h2);
        press(4'b1010);
        check("sim_q1", q_count, 4'h1);
        tick();
        check("sim_right", heading, 4'h3);
        check("sim_q0", q_count, 4'h0);

        // restart beats move_tick.
        press(4'b0010);
        check("rt_pre_q1", q_count, 4'h1);
        restart   = 1'b1;
        move_tick = 1'b1;
        cycles(1);
        restart   = 1'b0;
        move_tick = 1'b0;
        check("rt_heading", heading, 4'h3);
        check("rt_qcount", q_count, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
